// File: rtl/plot_scan_sequencer_if.sv
// Pixel bus between the frame BRAM read port, plot_scan_sequencer (master) and plotter_control (slave).
// The slave modport covers both the BRAM read data return and the plotter ready handshake.
interface plot_scan_sequencer_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] rd_addr_out;
    logic              rd_data_in;
    logic              pixel_value_out;
    logic              pixel_valid_out;
    logic              ready_in;
    logic [10:0]       hcount_out;
    logic [9:0]        vcount_out;

    modport master (
        output rd_addr_out,
        output pixel_value_out,
        output pixel_valid_out,
        output hcount_out,
        output vcount_out,
        input  rd_data_in,
        input  ready_in
    );

    modport slave (
        input  rd_addr_out,
        input  pixel_value_out,
        input  pixel_valid_out,
        input  hcount_out,
        input  vcount_out,
        output rd_data_in,
        output ready_in
    );
endinterface

// File: rtl/plot_scan_sequencer.sv
// Walks the frozen black/white frame BRAM pixel by pixel and hands each pixel to plotter_control.
// Optional macro PLOT_SERPENTINE_EN: odd rows are traversed right to left.
module plot_scan_sequencer #(
    parameter int IMG_W         = 106,
    parameter int IMG_H         = 80,
    parameter int ADDR_W        = 17,
    parameter int RD_LAT        = 2,
    parameter int FREEZE_CYCLES = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in_n,
    input  logic                  start_in,
    input  logic                  enable_in,
    input  logic                  abort_in,
    output logic                  freeze_out,
    output logic                  busy_out,
    output logic                  done_out,
    plot_scan_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        FREEZE,
        FETCH,
        WAIT_RD,
        PRESENT,
        ADVANCE,
        DONE
    } state_t;

    localparam int CNT_MAX = (FREEZE_CYCLES > RD_LAT) ? FREEZE_CYCLES : RD_LAT;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [10:0]       col_q, col_d;
    logic [9:0]        row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              value_q, value_d;
    logic              valid_q, valid_d;
    logic [10:0]       hcount_q, hcount_d;
    logic [9:0]        vcount_q, vcount_d;
    logic              freeze_q, freeze_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic row_end;
    logic last_pixel;
    logic transfer;

    // Row end depends on the walk direction of the current row
`ifdef PLOT_SERPENTINE_EN
    assign row_end = row_q[0] ? (col_q == 11'd0) : (col_q == 11'(IMG_W - 1));
`else
    assign row_end = (col_q == 11'(IMG_W - 1));
`endif
    assign last_pixel = row_end && (row_q == 10'(IMG_H - 1));
    assign transfer   = valid_q && bus.ready_in;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over every other transition, including a same-cycle transfer
    always_comb begin
        state_d = state_q;
        if (abort_in && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        state_d = FREEZE;
                    end
                end
                FREEZE: begin
                    if (cnt_q == CNT_W'(FREEZE_CYCLES - 1)) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    state_d = WAIT_RD;
                end
                WAIT_RD: begin
                    if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                        state_d = PRESENT;
                    end
                end
                PRESENT: begin
                    if (transfer) begin
                        state_d = ADVANCE;
                    end
                end
                ADVANCE: begin
                    state_d = last_pixel ? DONE : FETCH;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d      = '0;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        rd_addr_d  = rd_addr_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;

        case (state_q)
            FREEZE: begin
                cnt_d = cnt_q + 1'b1;
            end
            WAIT_RD: begin
                cnt_d = cnt_q + 1'b1;
                if (state_d == PRESENT) begin
                    value_d  = bus.rd_data_in;
                    hcount_d = col_q;
                    vcount_d = row_q;
                    valid_d  = enable_in;
                end
            end
            PRESENT: begin
                valid_d = (state_d == PRESENT) && enable_in;
            end
            ADVANCE: begin
                // The address is updated incrementally so no multiplier is needed
                if (!last_pixel) begin
`ifdef PLOT_SERPENTINE_EN
                    if (row_end) begin
                        row_d      = row_q + 10'd1;
                        row_base_d = row_base_q + ADDR_W'(IMG_W);
                    end else if (row_q[0]) begin
                        col_d = col_q - 11'd1;
                    end else begin
                        col_d = col_q + 11'd1;
                    end
`else
                    if (row_end) begin
                        col_d      = '0;
                        row_d      = row_q + 10'd1;
                        row_base_d = row_base_q + ADDR_W'(IMG_W);
                    end else begin
                        col_d = col_q + 11'd1;
                    end
`endif
                    rd_addr_d = row_base_d + ADDR_W'(col_d);
                end
            end
            default: begin
            end
        endcase

        if (state_d == IDLE) begin
            col_d      = '0;
            row_d      = '0;
            row_base_d = '0;
            rd_addr_d  = '0;
        end

        freeze_d = (state_d != IDLE) && (state_d != DONE);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            cnt_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            rd_addr_q  <= '0;
            value_q    <= 1'b0;
            valid_q    <= 1'b0;
            hcount_q   <= '0;
            vcount_q   <= '0;
            freeze_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            rd_addr_q  <= rd_addr_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            freeze_q   <= freeze_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rd_addr_out     = rd_addr_q;
    assign bus.pixel_value_out = value_q;
    assign bus.pixel_valid_out = valid_q;
    assign bus.hcount_out      = hcount_q;
    assign bus.vcount_out      = vcount_q;
    assign freeze_out          = freeze_q;
    assign busy_out            = busy_q;
    assign done_out            = done_q;

endmodule

// File: tb/tb_plot_scan_sequencer.sv
// Bench for plot_scan_sequencer on a 4x3 frame with a 2-cycle BRAM model.
// Define PLOT_SERPENTINE_EN on both bench and RTL to exercise the serpentine walk.
`timescale 1ns/1ps
module tb_plot_scan_sequencer;

    localparam int IMG_W         = 4;
    localparam int IMG_H         = 3;
    localparam int ADDR_W        = 17;
    localparam int RD_LAT        = 2;
    localparam int FREEZE_CYCLES = 4;
    localparam int NPIX          = IMG_W * IMG_H;
    localparam int FIRST_VALID   = 2 + FREEZE_CYCLES + RD_LAT;
    localparam int NEXT_GAP      = 3 + RD_LAT;
    localparam int DONE_CYCLE    = FIRST_VALID + NEXT_GAP * (NPIX - 1) + 2;

    logic clk_in    = 1'b0;
    logic rst_in_n  = 1'b1;
    logic start_in  = 1'b0;
    logic enable_in = 1'b0;
    logic abort_in  = 1'b0;
    logic ready_tb  = 1'b0;
    logic freeze_out;
    logic busy_out;
    logic done_out;

    plot_scan_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    plot_scan_sequencer #(
        .IMG_W        (IMG_W),
        .IMG_H        (IMG_H),
        .ADDR_W       (ADDR_W),
        .RD_LAT       (RD_LAT),
        .FREEZE_CYCLES(FREEZE_CYCLES)
    ) dut (
        .clk_in    (clk_in),
        .rst_in_n  (rst_in_n),
        .start_in  (start_in),
        .enable_in (enable_in),
        .abort_in  (abort_in),
        .freeze_out(freeze_out),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .bus       (bus)
    );

    always #5 clk_in = ~clk_in;

    // Frame BRAM with a two-stage read pipeline
    logic [15:0] mem;
    logic [1:0]  rd_pipe = 2'b00;
    always @(posedge clk_in) begin
        rd_pipe <= {rd_pipe[0], (bus.rd_addr_out < ADDR_W'(NPIX)) ? mem[bus.rd_addr_out[3:0]] : 1'b0};
    end
    assign bus.rd_data_in = rd_pipe[1];
    assign bus.ready_in   = ready_tb;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int t_addr[$];
    int t_val[$];
    int t_h[$];
    int t_v[$];
    int t_cyc[$];
    int d_cyc[$];

    always @(negedge clk_in) begin
        if (rst_in_n && !abort_in && bus.pixel_valid_out && bus.ready_in) begin
            t_addr.push_back(int'(bus.rd_addr_out));
            t_val.push_back(int'(bus.pixel_value_out));
            t_h.push_back(int'(bus.hcount_out));
            t_v.push_back(int'(bus.vcount_out));
            t_cyc.push_back(cyc);
        end
        if (done_out) d_cyc.push_back(cyc);
    end

    int n_checks = 0;
    int n_fail   = 0;
    int c0       = 0;

    typedef struct {
        int ready_hold;
        int en_drop;
        int exp_addr;
        int exp_val;
        int exp_h;
        int exp_v;
    } vec_t;

    vec_t vecs [NPIX];
    int   exp_order [NPIX];

    function automatic int pixRow(input int k);
        return k / IMG_W;
    endfunction

    function automatic int pixCol(input int k);
`ifdef PLOT_SERPENTINE_EN
        if ((pixRow(k) % 2) == 1) return IMG_W - 1 - (k % IMG_W);
`endif
        return k % IMG_W;
    endfunction

    function automatic int pixAddr(input int k);
        return pixRow(k) * IMG_W + pixCol(k);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic enable, input logic abort, input logic ready);
        @(posedge clk_in);
        #1;
        start_in  = start;
        enable_in = enable;
        abort_in  = abort;
        ready_tb  = ready;
    endtask

    task automatic startPass(input logic ready);
        applyStimulus(1'b1, 1'b1, 1'b0, ready);
        c0 = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0, ready);
    endtask

    task automatic clearLog();
        t_addr.delete();
        t_val.delete();
        t_h.delete();
        t_v.delete();
        t_cyc.delete();
        d_cyc.delete();
    endtask

    task automatic waitValid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk_in);
            #1;
            if (bus.pixel_valid_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitTransfers(input int n, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk_in);
            #1;
            if (t_addr.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitDone(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk_in);
            #1;
            if (d_cyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_freeze"}, int'(freeze_out), 0);
        checkOutput({tag, "_busy"}, int'(busy_out), 0);
        checkOutput({tag, "_done"}, int'(done_out), 0);
        checkOutput({tag, "_valid"}, int'(bus.pixel_valid_out), 0);
        checkOutput({tag, "_value"}, int'(bus.pixel_value_out), 0);
        checkOutput({tag, "_addr"}, int'(bus.rd_addr_out), 0);
        checkOutput({tag, "_hcount"}, int'(bus.hcount_out), 0);
        checkOutput({tag, "_vcount"}, int'(bus.vcount_out), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no end, expected end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit   ok;
        int   bad;
        int   bad2;
        int   n0;
        int   cap_addr;
        int   cap_val;
        int   cap_h;
        int   cap_v;
        int   a;
        logic [3:0] ai;

`ifdef PLOT_SERPENTINE_EN
        exp_order = '{0, 1, 2, 3, 7, 6, 5, 4, 8, 9, 10, 11};
`else
        exp_order = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
`endif
        for (int k = 0; k < NPIX; k++) begin
            vecs[k] = '{ready_hold: 0, en_drop: 0, exp_addr: exp_order[k], exp_val: exp_order[k] % 2,
                        exp_h: exp_order[k] % IMG_W, exp_v: exp_order[k] / IMG_W};
        end
        vecs[2].ready_hold = 20;
        vecs[5].en_drop    = 10;
        vecs[9].ready_hold = 3;
        vecs[9].en_drop    = 4;

        for (int i = 0; i < 16; i++) mem[i] = 1'(i % 2);

        #2 rst_in_n = 1'b0;
        #1 checkAllZero("reset");
        #20;
        @(posedge clk_in);
        #1 rst_in_n = 1'b1;

        $display("[TB] basic pass, ready tied high");
        clearLog();
        startPass(1'b1);
        bad  = 0;
        bad2 = 0;
        for (int ci = 1; ci <= DONE_CYCLE + 3; ci++) begin
            @(negedge clk_in);
            #1;
            start_in = (ci == 20);
            if (freeze_out !== (ci < DONE_CYCLE)) bad++;
            if (busy_out !== (ci <= DONE_CYCLE)) bad2++;
        end
        start_in = 1'b0;
        checkOutput("basic_freeze_window_errors", bad, 0);
        checkOutput("basic_busy_window_errors", bad2, 0);
        checkOutput("basic_transfer_count", t_addr.size(), NPIX);
        for (int k = 0; k < NPIX && k < t_addr.size(); k++) begin
            checkOutput($sformatf("basic_addr[%0d]", k), t_addr[k], vecs[k].exp_addr);
            checkOutput($sformatf("basic_value[%0d]", k), t_val[k], vecs[k].exp_val);
            checkOutput($sformatf("basic_hcount[%0d]", k), t_h[k], vecs[k].exp_h);
            checkOutput($sformatf("basic_vcount[%0d]", k), t_v[k], vecs[k].exp_v);
            checkOutput($sformatf("basic_cycle[%0d]", k), t_cyc[k] - c0, FIRST_VALID + NEXT_GAP * k);
        end
        checkOutput("basic_done_count", d_cyc.size(), 1);
        if (d_cyc.size() > 0) checkOutput("basic_done_cycle", d_cyc[0] - c0, DONE_CYCLE);

        $display("[TB] table-driven stalls");
        clearLog();
        startPass(1'b0);
        for (int k = 0; k < NPIX; k++) begin
            waitValid(60, ok);
            checkOutput($sformatf("stall_valid_timeout[%0d]", k), int'(ok), 1);
            if (!ok) break;
            checkOutput($sformatf("stall_addr[%0d]", k), int'(bus.rd_addr_out), vecs[k].exp_addr);
            checkOutput($sformatf("stall_value[%0d]", k), int'(bus.pixel_value_out), vecs[k].exp_val);
            checkOutput($sformatf("stall_hcount[%0d]", k), int'(bus.hcount_out), vecs[k].exp_h);
            checkOutput($sformatf("stall_vcount[%0d]", k), int'(bus.vcount_out), vecs[k].exp_v);
            cap_addr = int'(bus.rd_addr_out);
            cap_val  = int'(bus.pixel_value_out);
            cap_h    = int'(bus.hcount_out);
            cap_v    = int'(bus.vcount_out);
            n0       = t_addr.size();
            bad      = 0;
            for (int i = 0; i < vecs[k].ready_hold; i++) begin
                @(negedge clk_in);
                #1;
                if (bus.pixel_valid_out !== 1'b1) bad++;
                if (int'(bus.rd_addr_out) != cap_addr || int'(bus.pixel_value_out) != cap_val) bad++;
                if (t_addr.size() != n0) bad++;
            end
            if (vecs[k].en_drop > 0) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < vecs[k].en_drop; i++) begin
                    @(negedge clk_in);
                    #1;
                    if (i > 0 && bus.pixel_valid_out !== 1'b0) bad++;
                    if (int'(bus.hcount_out) != cap_h || int'(bus.vcount_out) != cap_v) bad++;
                    if (int'(bus.rd_addr_out) != cap_addr || int'(bus.pixel_value_out) != cap_val) bad++;
                    if (busy_out !== 1'b1) bad++;
                end
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
                waitValid(5, ok);
                checkOutput($sformatf("stall_resume[%0d]", k), int'(ok), 1);
                checkOutput($sformatf("stall_resume_hcount[%0d]", k), int'(bus.hcount_out), cap_h);
            end
            if (vecs[k].ready_hold > 0 || vecs[k].en_drop > 0) begin
                checkOutput($sformatf("stall_hold_errors[%0d]", k), bad, 0);
            end
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            @(negedge clk_in);
            #1;
            checkOutput($sformatf("stall_one_transfer[%0d]", k), t_addr.size(), n0 + 1);
            if (t_addr.size() > n0) begin
                checkOutput($sformatf("stall_xfer_addr[%0d]", k), t_addr[n0], vecs[k].exp_addr);
            end
        end
        waitDone(20, ok);
        checkOutput("stall_done_seen", int'(ok), 1);

        $display("[TB] abort at fifth pixel");
        clearLog();
        startPass(1'b1);
        waitTransfers(4, 100, ok);
        checkOutput("abort_reach_4", int'(ok), 1);
        waitValid(20, ok);
        checkOutput("abort_fifth_valid", int'(ok), 1);
        abort_in = 1'b1;
        @(posedge clk_in);
        #1;
        abort_in = 1'b0;
        checkOutput("abort_valid", int'(bus.pixel_valid_out), 0);
        checkOutput("abort_freeze", int'(freeze_out), 0);
        checkOutput("abort_busy", int'(busy_out), 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            #1;
            if (busy_out !== 1'b0 || bus.pixel_valid_out !== 1'b0) bad++;
        end
        checkOutput("abort_stays_idle_errors", bad, 0);
        checkOutput("abort_no_done", d_cyc.size(), 0);
        clearLog();
        startPass(1'b1);
        waitTransfers(1, 40, ok);
        checkOutput("restart_first_timeout", int'(ok), 1);
        if (ok) begin
            checkOutput("restart_first_addr", t_addr[0], pixAddr(0));
            checkOutput("restart_first_cycle", t_cyc[0] - c0, FIRST_VALID);
        end
        waitDone(200, ok);
        checkOutput("restart_done_seen", int'(ok), 1);
        checkOutput("restart_transfer_count", t_addr.size(), NPIX);

        $display("[TB] reset during read wait");
        clearLog();
        startPass(1'b1);
        waitTransfers(5, 100, ok);
        checkOutput("rst_reach_5", int'(ok), 1);
        repeat (3) @(posedge clk_in);
        #3 rst_in_n = 1'b0;
        #1 checkAllZero("midrst");
        repeat (2) @(posedge clk_in);
        #1 rst_in_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_in);
            #1;
            if (busy_out !== 1'b0 || bus.pixel_valid_out !== 1'b0 || freeze_out !== 1'b0) bad++;
        end
        checkOutput("rst_stays_idle_errors", bad, 0);
        checkOutput("rst_no_new_transfer", t_addr.size(), 5);

        $display("[TB] randomized handshake against reference walk");
        for (int i = 0; i < 16; i++) mem[i] = 1'($urandom_range(0, 1));
        clearLog();
        startPass(1'b0);
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk_in);
            #1;
            ready_tb  = ($urandom_range(0, 99) < 60);
            enable_in = ($urandom_range(0, 99) < 80);
            if (d_cyc.size() > 0) break;
        end
        ready_tb  = 1'b0;
        enable_in = 1'b1;
        repeat (4) @(negedge clk_in);
        checkOutput("rand_done_count", d_cyc.size(), 1);
        checkOutput("rand_transfer_count", t_addr.size(), NPIX);
        for (int k = 0; k < NPIX && k < t_addr.size(); k++) begin
            a  = pixAddr(k);
            ai = 4'(a);
            checkOutput($sformatf("rand_addr[%0d]", k), t_addr[k], a);
            checkOutput($sformatf("rand_value[%0d]", k), t_val[k], int'(mem[ai]));
            checkOutput($sformatf("rand_hcount[%0d]", k), t_h[k], pixCol(k));
            checkOutput($sformatf("rand_vcount[%0d]", k), t_v[k], pixRow(k));
        end
        if (d_cyc.size() > 0 && t_cyc.size() > 0) begin
            checkOutput("rand_done_latency", d_cyc[0] - t_cyc[t_cyc.size() - 1], 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plot_scan_sequencer.md
Name: plot_scan_sequencer

Overview:
- Sequences the stepper-plotter drawing pass over the 1-bit downsampled black/white frame BRAM (IMG_W x IMG_H, one word per pixel).
- Freezes BRAM writes, then walks every pixel in scan order. Each pixel is fetched through the BRAM read port (fixed read latency) and handed to plotter_control one at a time over a valid/ready handshake.
- Sits between the black_white frame BRAM read port and plotter_control; runs on clk_65mhz.

Parameters:
- IMG_W, 106, pixels per row
- IMG_H, 80, rows per frame
- ADDR_W, 17, BRAM address width
- RD_LAT, 2, BRAM read latency in cycles (address to data), >=1
- FREEZE_CYCLES, 4, cycles between asserting freeze and the first read (lets in-flight writes drain), >=1

Ports:
- clk_in  input  1  system clock (clk_65mhz)
- rst_in_n  input  1  asynchronous, active-low reset
- start_in  input  1  begin a drawing pass; sampled only in IDLE
- enable_in  input  1  plotter enable; low pauses handshake
- abort_in  input  1  cancel pass; returns to IDLE
- freeze_out  output  1  high = inhibit BRAM writes; ANDed into the write enable
- rd_addr_out  output  ADDR_W  BRAM read address
- rd_data_in  input  1  BRAM read data
- pixel_value_out  output  1  pixel presented to plotter
- pixel_valid_out  output  1  pixel_value_out valid
- ready_in  input  1  plotter ready to accept (level)
- hcount_out  output  11  column of presented pixel
- vcount_out  output  10  row of presented pixel
- busy_out  output  1  high in any state other than IDLE
- done_out  output  1  one-cycle pulse when last pixel accepted

Behaviour:
- Reset (async assert, sync release) values:
  - state = IDLE.
  - freeze_out, pixel_valid_out, pixel_value_out, busy_out, done_out = 0.
  - rd_addr_out, hcount_out, vcount_out = 0.
- All outputs are registered.
- States: IDLE, FREEZE, FETCH, WAIT_RD, PRESENT, ADVANCE, DONE.
- IDLE:
  - start_in=1 -> FREEZE.
  - Clear col/row/row_base; rd_addr_out=0.
  - freeze_out rises on the FREEZE entry cycle.
- FREEZE: hold FREEZE_CYCLES cycles -> FETCH.
- FETCH: rd_addr_out = row_base + col (incremental; no multiplier). One cycle -> WAIT_RD.
- WAIT_RD:
  - Count RD_LAT cycles.
  - On the last cycle register rd_data_in into pixel_value_out; col/row go to hcount_out/vcount_out -> PRESENT.
- PRESENT:
  - pixel_valid_out = enable_in (combinationally gated before its output register).
  - Transfer when pixel_valid_out && ready_in on a clock edge -> ADVANCE; valid drops the next cycle.
  - ready_in without valid is ignored.
  - enable_in low holds the state and value; valid is low while enable_in is low.
- ADVANCE:
  - col+1. At col==IMG_W-1: col=0, row+1, row_base+=IMG_W.
  - At the last pixel (row==IMG_H-1, col==IMG_W-1) -> DONE; otherwise -> FETCH.
- DONE: done_out=1 for one cycle, freeze_out drops the same cycle -> IDLE.
- Latency:
  - start sampled at cycle 0 -> first pixel_valid_out at cycle 2+FREEZE_CYCLES+RD_LAT (8 with defaults).
  - Accept-to-next-valid = 3+RD_LAT cycles (5 with defaults).
- abort_in in any non-IDLE state -> IDLE next cycle; valid and freeze cleared, done_out not pulsed. Abort has priority over a simultaneous transfer.
- start_in while busy is ignored.
- Address stays within 0..IMG_W*IMG_H-1; counters never wrap past the frame.

Optional Feature:
- Macro: PLOT_SERPENTINE_EN.
- Defined:
  - Odd rows are traversed right to left (col counts IMG_W-1 down to 0) to halve plotter carriage travel.
  - rd_addr_out = row_base + col still holds.
  - The row advances at col==0 on odd rows.
  - The last pixel is (IMG_H-1, 0) if IMG_H is even, else (IMG_H-1, IMG_W-1).
- Not defined: every row is traversed left to right.

Test Plan:
- IMG_W=4, IMG_H=3; BRAM model RD_LAT=2 holding pattern addr[0]; ready_in tied 1, enable_in=1; pulse start.
  - Expect 12 transfers, addresses 0..11 in order, pixel values alternating 0,1.
  - First valid at cycle 8; done_out pulses once after the 12th transfer; freeze_out high from cycle 1 until done.
- Same setup; ready_in low for 20 cycles in PRESENT.
  - valid and value held steady; no address change; exactly one transfer when ready returns.
- enable_in dropped mid-PRESENT for 10 cycles.
  - valid low during the drop; state, hcount and vcount unchanged; resumes with the same pixel.
- abort_in at the 5th pixel.
  - IDLE next cycle; freeze_out=0, busy_out=0, no done_out.
  - A new start restarts at address 0.
- rst_in_n pulsed low mid-WAIT_RD.
  - All outputs zero immediately (asynchronously); no transfer after release until start.
- PLOT_SERPENTINE_EN defined, 4x3.
  - Address order 0,1,2,3,7,6,5,4,8,9,10,11.
  - hcount sequence mirrors the addresses; done after address 11.
